// File: rtl/sdp_memory_pkg.sv
// Shared types and helpers for the sdp_memory simple-dual-port RAM.
package sdp_memory_pkg;

   // Widest word the byte-merge helper handles; callers cast to their own WIDTH.
   localparam int unsigned MERGE_W    = 1024;
   localparam int unsigned MERGE_BE_W = MERGE_W / 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Replace the bytes of old_word selected by be with the matching bytes of new_word.
   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]    old_word,
      input logic [MERGE_W-1:0]    new_word,
      input logic [MERGE_BE_W-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_word;
      for (int i = 0; i < int'(MERGE_BE_W); i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sdp_mem_init_ctrl.sv
// Post-reset clear-sweep controller: walks every address once, then opens the ports.
module sdp_mem_init_ctrl
   import sdp_memory_pkg::*;
#(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output state_t            state,
   output logic [ADDR_W-1:0] sweep_addr,
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            next_state;
   logic [ADDR_W-1:0] next_addr;
   logic              next_done;

   // State, sweep counter and init_done registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         sweep_addr <= '0;
         init_done  <= 1'b0;
      end else begin
         state      <= next_state;
         sweep_addr <= next_addr;
         init_done  <= next_done;
      end
   end

   // Sweep one word per cycle; leave INIT on the edge that clears the last word.
   always_comb begin
      next_state = state;
      next_addr  = sweep_addr;
      next_done  = init_done;
      case (state)
         INIT: begin
            next_addr = sweep_addr + ADDR_W'(1);
            if (sweep_addr == LAST_ADDR) begin
               next_state = RUN;
               next_addr  = '0;
               next_done  = 1'b1;
            end
         end
         RUN: begin
            next_state = RUN;
         end
         default: begin
            next_state = INIT;
            next_addr  = '0;
            next_done  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sdp_memory.sv
// Single-clock simple-dual-port RAM, byte-enabled writes, 2-cycle read latency,
// cleared by a hardware sweep after every reset.
// Optional build macro MEM_BYPASS_EN: write-first forwarding on a same-address
// read/write collision (read-first when undefined).
module sdp_memory
   import sdp_memory_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wraddr,
   input  logic [WIDTH-1:0]   din,
   input  logic [WIDTH/8-1:0] be,
   input  logic               re,
   input  logic [ADDR_W-1:0]  rdaddr,
   output logic [WIDTH-1:0]   q,
   output logic               q_valid,
   output logic               init_done
);

   localparam int unsigned     BE_W    = WIDTH / 8;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic              we_d;
   logic [ADDR_W-1:0] wraddr_d;
   logic [WIDTH-1:0]  din_d;
   logic [BE_W-1:0]   be_d;
   logic              re_d;
   logic [ADDR_W-1:0] rdaddr_d;

   logic [WIDTH-1:0]  mem [DEPTH];

   state_t            state;
   logic [ADDR_W-1:0] sweep_addr;

   logic              wr_ok_c;
   logic              rd_ok_c;
   logic [WIDTH-1:0]  merged_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [WIDTH-1:0]  mem_data_c;
   logic [WIDTH-1:0]  rd_word_c;

   sdp_mem_init_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_ctrl (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .sweep_addr (sweep_addr),
      .init_done  (init_done)
   );

   // Stage 1: register every request input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_d     <= 1'b0;
         wraddr_d <= '0;
         din_d    <= '0;
         be_d     <= '0;
         re_d     <= 1'b0;
         rdaddr_d <= '0;
      end else begin
         we_d     <= we;
         wraddr_d <= wraddr;
         din_d    <= din;
         be_d     <= be;
         re_d     <= re;
         rdaddr_d <= rdaddr;
      end
   end

   // Address range checks and the byte-merged write word.
   always_comb begin
      wr_ok_c  = ({1'b0, wraddr_d} < DEPTH_X);
      rd_ok_c  = ({1'b0, rdaddr_d} < DEPTH_X);
      merged_c = WIDTH'(byte_merge(MERGE_W'(mem[wraddr_d]), MERGE_W'(din_d), MERGE_BE_W'(be_d)));
   end

   // Array write port: the clear sweep owns it during INIT, the request path during RUN.
   always_comb begin
      mem_we_c   = 1'b0;
      mem_addr_c = '0;
      mem_data_c = '0;
      if (state == INIT) begin
         mem_we_c   = 1'b1;
         mem_addr_c = sweep_addr;
      end else if (we_d && wr_ok_c) begin
         mem_we_c   = 1'b1;
         mem_addr_c = wraddr_d;
         mem_data_c = merged_c;
      end
   end

   // Storage array; contents are defined by the post-reset sweep, not by reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_addr_c] <= mem_data_c;
      end
   end

   // Read word: zero for out-of-range addresses, optional collision forwarding.
   always_comb begin
      rd_word_c = '0;
      if (rd_ok_c) begin
         rd_word_c = mem[rdaddr_d];
`ifdef MEM_BYPASS_EN
         if (we_d && (wraddr_d == rdaddr_d)) begin
            rd_word_c = merged_c;
         end
`endif
      end
   end

   // Stage 2 output: q holds between reads, q_valid suppressed during INIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (state == RUN) begin
         q_valid <= re_d;
         if (re_d) begin
            q <= rd_word_c;
         end
      end else begin
         q_valid <= 1'b0;
      end
   end

endmodule
